// File: rtl/count_capture_fifo_if.sv
// Valid/ready stream carrying captured counter snapshots from the capture FIFO
// to its consumer.
interface count_capture_fifo_if #(
  parameter int N = 8
);
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/count_capture_fifo.sv
// Snapshots count_in on each rising edge of event_in into a small FWFT FIFO
// and presents the snapshots on a valid/ready stream with a sticky overflow flag.
module count_capture_fifo #(
  parameter int N     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N-1:0]             count_in,
  input  logic                     event_in,
  count_capture_fifo_if.master     out_if,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LEVEL_MAX = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic          event_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [N-1:0]  mem [DEPTH];

  logic capture;
  logic full;
  logic empty;
  logic pop;
  logic do_push;
  logic drop;

  always_comb begin
    capture = event_in & ~event_q;
    full    = (fifo_level == LEVEL_MAX);
    empty   = (fifo_level == '0);
    pop     = ~empty & out_if.out_ready;
    // A simultaneous pop frees the slot, so a capture into a full FIFO is kept.
    do_push = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  assign out_if.out_valid = ~empty;
  assign out_if.out_data  = empty ? '0 : mem[rd_ptr];

  // NOTE: storage carries no reset; only pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= count_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_q    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      event_q <= event_in;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + LEVEL_ONE;
        2'b01:   fifo_level <= fifo_level - LEVEL_ONE;
        default: fifo_level <= fifo_level;
      endcase
      // A fresh drop outranks a clear requested in the same cycle.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

endmodule
